// File: rtl/rs_age_ordered_pkg.sv
// Shared widths, tag constant and the first-one finder used by the
// age-ordered reservation station.
package rs_age_ordered_pkg;

  localparam int RS_DEPTH     = 16;
  localparam int RS_ROB_W     = 4;
  localparam int RS_DATA_W    = 32;
  localparam int RS_OP_W      = 6;
  localparam int RS_CDB_PORTS = 2;

  typedef logic [RS_ROB_W-1:0]  tag_t;
  typedef logic [RS_OP_W-1:0]   op_t;
  typedef logic [RS_DATA_W-1:0] value_t;

  // A tag of zero means the operand is already present (no producer).
  localparam tag_t TAG_NONE = '0;

  // Index of the lowest set bit; 0 when no bit is set. Covers up to 32 entries.
  function automatic int first_one(input logic [31:0] vec);
    first_one = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) first_one = i;
    end
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: an entry wins when it is ready and no other ready
// entry is marked older than it in the age matrix.
module rs_age_select
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*DEPTH-1:0] age,
  output logic [DEPTH-1:0]       grant,
  output logic [IDX_W-1:0]       index,
  output logic                   has_ready
);

  // age[i*DEPTH + j] set means entry i was dispatched before entry j.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
    logic [DEPTH-1:0] older_col;

    always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
        older_col[j] = age[j*DEPTH + gi];
      end
    end

    assign grant[gi] = ready[gi] && !(|(ready & older_col));
  end

  always_comb begin
    index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) index = index | IDX_W'(i);
    end
  end

  assign has_ready = |ready;

endmodule

// File: rtl/rs_age_ordered.sv
// Reservation station that captures operands from several CDB ports and
// issues the oldest ready op through a registered valid/ready stage.
module rs_age_ordered
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH,
  parameter int ROB_W     = RS_ROB_W,
  parameter int DATA_W    = RS_DATA_W,
  parameter int OP_W      = RS_OP_W,
  parameter int CDB_PORTS = RS_CDB_PORTS
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        disp_valid,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [DATA_W-1:0]           disp_vj,
  input  logic [DATA_W-1:0]           disp_vk,
  input  logic [ROB_W-1:0]            disp_qj,
  input  logic [ROB_W-1:0]            disp_qk,
  input  logic [ROB_W-1:0]            disp_dest,
  output logic                        full,
  output logic                        one_vacancy,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*ROB_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_value,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_op,
  output logic [DATA_W-1:0]           issue_vj,
  output logic [DATA_W-1:0]           issue_vk,
  output logic [ROB_W-1:0]            issue_dest
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ROB_W-1:0] TAG_ZERO = ROB_W'(TAG_NONE);

  logic [DEPTH-1:0]  busy_reg, busy_next;
  logic [OP_W-1:0]   op_reg   [DEPTH];
  logic [OP_W-1:0]   op_next  [DEPTH];
  logic [DATA_W-1:0] vj_reg   [DEPTH];
  logic [DATA_W-1:0] vj_next  [DEPTH];
  logic [DATA_W-1:0] vk_reg   [DEPTH];
  logic [DATA_W-1:0] vk_next  [DEPTH];
  logic [ROB_W-1:0]  qj_reg   [DEPTH];
  logic [ROB_W-1:0]  qj_next  [DEPTH];
  logic [ROB_W-1:0]  qk_reg   [DEPTH];
  logic [ROB_W-1:0]  qk_next  [DEPTH];
  logic [ROB_W-1:0]  dest_reg [DEPTH];
  logic [ROB_W-1:0]  dest_next[DEPTH];
  logic [DEPTH-1:0]  older_reg [DEPTH];
  logic [DEPTH-1:0]  older_next[DEPTH];

  logic              issue_valid_reg;
  logic [OP_W-1:0]   issue_op_reg;
  logic [DATA_W-1:0] issue_vj_reg, issue_vk_reg;
  logic [ROB_W-1:0]  issue_dest_reg;

  logic [DEPTH-1:0]       ready;
  logic [DEPTH*DEPTH-1:0] age_flat;
  logic [DEPTH-1:0]       grant;
  logic [IDX_W-1:0]       sel_idx;
  logic                   has_ready;
  logic [31:0]            vacant_ext;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   accept;
  logic                   load;

  assign full        = &busy_reg;
  assign one_vacancy = $onehot(~busy_reg);
  assign vacant_ext  = 32'(~busy_reg);
  assign alloc_idx   = IDX_W'(first_one(vacant_ext));
  assign accept      = disp_valid && !full;
  assign load        = (!issue_valid_reg || issue_ready) && has_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign ready[gi] = busy_reg[gi] && (qj_reg[gi] == TAG_ZERO) && (qk_reg[gi] == TAG_ZERO);
    assign age_flat[gi*DEPTH +: DEPTH] = older_reg[gi];
  end

  rs_age_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready     (ready),
    .age       (age_flat),
    .grant     (grant),
    .index     (sel_idx),
    .has_ready (has_ready)
  );

  always_comb begin
    busy_next = busy_reg;
    for (int i = 0; i < DEPTH; i++) begin
      op_next[i]    = op_reg[i];
      vj_next[i]    = vj_reg[i];
      vk_next[i]    = vk_reg[i];
      qj_next[i]    = qj_reg[i];
      qk_next[i]    = qk_reg[i];
      dest_next[i]  = dest_reg[i];
      older_next[i] = older_reg[i];
      // Ports scanned high to low so the lowest matching port is applied last.
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (busy_reg[i] && cdb_valid[p] && qj_reg[i] != TAG_ZERO
            && cdb_tag[p*ROB_W +: ROB_W] == qj_reg[i]) begin
          vj_next[i] = cdb_value[p*DATA_W +: DATA_W];
          qj_next[i] = TAG_ZERO;
        end
        if (busy_reg[i] && cdb_valid[p] && qk_reg[i] != TAG_ZERO
            && cdb_tag[p*ROB_W +: ROB_W] == qk_reg[i]) begin
          vk_next[i] = cdb_value[p*DATA_W +: DATA_W];
          qk_next[i] = TAG_ZERO;
        end
      end
    end

    if (accept) begin
      busy_next[alloc_idx] = 1'b1;
      op_next[alloc_idx]   = disp_op;
      dest_next[alloc_idx] = disp_dest;
      vj_next[alloc_idx]   = disp_vj;
      vk_next[alloc_idx]   = disp_vk;
      qj_next[alloc_idx]   = disp_qj;
      qk_next[alloc_idx]   = disp_qk;
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && disp_qj != TAG_ZERO && cdb_tag[p*ROB_W +: ROB_W] == disp_qj) begin
          vj_next[alloc_idx] = cdb_value[p*DATA_W +: DATA_W];
          qj_next[alloc_idx] = TAG_ZERO;
        end
        if (cdb_valid[p] && disp_qk != TAG_ZERO && cdb_tag[p*ROB_W +: ROB_W] == disp_qk) begin
          vk_next[alloc_idx] = cdb_value[p*DATA_W +: DATA_W];
          qk_next[alloc_idx] = TAG_ZERO;
        end
      end
      // New entry is younger than everything currently held.
      older_next[alloc_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_next[j][alloc_idx] = busy_reg[j];
      end
    end

    if (load) busy_next[sel_idx] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_reg        <= '0;
      issue_valid_reg <= 1'b0;
      issue_op_reg    <= '0;
      issue_vj_reg    <= '0;
      issue_vk_reg    <= '0;
      issue_dest_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_reg        <= '0;
        issue_valid_reg <= 1'b0;
      end else begin
        busy_reg <= busy_next;
        for (int i = 0; i < DEPTH; i++) begin
          op_reg[i]    <= op_next[i];
          vj_reg[i]    <= vj_next[i];
          vk_reg[i]    <= vk_next[i];
          qj_reg[i]    <= qj_next[i];
          qk_reg[i]    <= qk_next[i];
          dest_reg[i]  <= dest_next[i];
          older_reg[i] <= older_next[i];
        end
        if (load) begin
          issue_valid_reg <= 1'b1;
          issue_op_reg    <= op_reg[sel_idx];
          issue_vj_reg    <= vj_reg[sel_idx];
          issue_vk_reg    <= vk_reg[sel_idx];
          issue_dest_reg  <= dest_reg[sel_idx];
        end else if (issue_ready) begin
          issue_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign issue_valid = issue_valid_reg;
  assign issue_op    = issue_op_reg;
  assign issue_vj    = issue_vj_reg;
  assign issue_vk    = issue_vk_reg;
  assign issue_dest  = issue_dest_reg;

endmodule

// File: tb/tb_rs_age_ordered.sv
// Directed bench for rs_age_ordered: age-ordered issue, CDB capture,
// back-pressure, flush, freeze and reset.
module tb_rs_age_ordered;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        disp_valid;
  logic [5:0]  disp_op;
  logic [31:0] disp_vj, disp_vk;
  logic [3:0]  disp_qj, disp_qk, disp_dest;
  logic        full, one_vacancy;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [3:0]  issue_dest;

  int checks = 0;
  int errors = 0;

  rs_age_ordered dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .disp_valid  (disp_valid),
    .disp_op     (disp_op),
    .disp_vj     (disp_vj),
    .disp_vk     (disp_vk),
    .disp_qj     (disp_qj),
    .disp_qk     (disp_qk),
    .disp_dest   (disp_dest),
    .full        (full),
    .one_vacancy (one_vacancy),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .issue_dest  (issue_dest)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    disp_op = '0; disp_vj = '0; disp_vk = '0;
    disp_qj = '0; disp_qk = '0; disp_dest = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    flush_in = 1'b0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                          input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest);
    disp_valid = 1'b1;
    disp_op = op; disp_qj = qj; disp_qk = qk;
    disp_vj = vj; disp_vk = vk; disp_dest = dest;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; issue_ready = 1'b0;
    idle();
    step(); step();
    rst_in = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", issue_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (one_vacancy !== 1'b0) begin errors++; $display("FAIL reset_one_vac got %b exp 0", one_vacancy); end
    checks++; if (issue_op !== 6'h00 || issue_vj !== 32'h0 || issue_dest !== 4'h0) begin
      errors++; $display("FAIL reset_fields got op=%h vj=%h dest=%h exp 0", issue_op, issue_vj, issue_dest);
    end
    $display("reset done");
  endtask

  task automatic test_single();
    issue_ready = 1'b0;
    dispatch(6'h13, 4'd0, 4'd0, 32'h11, 32'h22, 4'd1);
    step();
    idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h13) begin
      errors++; $display("FAIL single_issue got v=%b op=%h exp v=1 op=13", issue_valid, issue_op);
    end
    checks++; if (issue_vj !== 32'h11 || issue_vk !== 32'h22 || issue_dest !== 4'd1) begin
      errors++; $display("FAIL single_fields got vj=%h vk=%h dest=%h exp 11 22 1", issue_vj, issue_vk, issue_dest);
    end
    checks++; if (full !== 1'b0 || one_vacancy !== 1'b0) begin
      errors++; $display("FAIL single_freed got full=%b onev=%b exp 0 0", full, one_vacancy);
    end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", issue_valid); end
    issue_ready = 1'b0;
    $display("single op 13 issued");
  endtask

  task automatic test_age_order();
    issue_ready = 1'b0;
    dispatch(6'h0A, 4'd3, 4'd0, 32'h0, 32'h5, 4'd2);
    step();
    dispatch(6'h0B, 4'd0, 4'd0, 32'hB1, 32'hB2, 4'd3);
    step();
    idle();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_value = {32'h0, 32'h33};
    step();
    idle();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h0B) begin
      errors++; $display("FAIL age_first got v=%b op=%h exp v=1 op=0b", issue_valid, issue_op);
    end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h0A || issue_vj !== 32'h33) begin
      errors++; $display("FAIL age_second got v=%b op=%h vj=%h exp v=1 op=0a vj=33", issue_valid, issue_op, issue_vj);
    end
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL age_drain got %b exp 0", issue_valid); end
    issue_ready = 1'b0;
    $display("age order B then A");
  endtask

  task automatic test_fill();
    issue_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dispatch(6'(i), 4'd5, 4'd0, 32'h0, 32'(i), 4'(i % 15 + 1));
      step();
      if (i == 14) begin
        checks++; if (one_vacancy !== 1'b1 || full !== 1'b0) begin
          errors++; $display("FAIL fill_one_vac got onev=%b full=%b exp 1 0", one_vacancy, full);
        end
      end
    end
    checks++; if (full !== 1'b1 || one_vacancy !== 1'b0) begin
      errors++; $display("FAIL fill_full got full=%b onev=%b exp 1 0", full, one_vacancy);
    end
    dispatch(6'h3F, 4'd0, 4'd0, 32'h77, 32'h77, 4'd9);
    step();
    idle();
    checks++; if (full !== 1'b1 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL fill_reject got full=%b v=%b exp 1 0", full, issue_valid);
    end
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_value = {32'h0, 32'hDEAD_BEEF};
    step();
    idle();
    issue_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      $display("fill issue op=%h vj=%h", issue_op, issue_vj);
      checks++; if (issue_valid !== 1'b1 || issue_op !== 6'(i)) begin
        errors++; $display("FAIL fill_order_%0d got v=%b op=%h exp v=1 op=%h", i, issue_valid, issue_op, 6'(i));
      end
      checks++; if (issue_vj !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL fill_vj_%0d got %h exp deadbeef", i, issue_vj);
      end
    end
    step();
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL fill_empty got v=%b full=%b exp 0 0", issue_valid, full);
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_forward();
    issue_ready = 1'b0;
    dispatch(6'h21, 4'd0, 4'd7, 32'h1, 32'h0, 4'd4);
    cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd9}; cdb_value = {32'h42, 32'h99};
    step();
    idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fwd_early got %b exp 0", issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h21 || issue_vk !== 32'h42 || issue_vj !== 32'h1) begin
      errors++; $display("FAIL fwd_issue got v=%b op=%h vj=%h vk=%h exp 1 21 1 42", issue_valid, issue_op, issue_vj, issue_vk);
    end
    issue_ready = 1'b1;
    dispatch(6'h22, 4'd6, 4'd0, 32'h0, 32'h0, 4'd5);
    step();
    idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain got %b exp 0", issue_valid); end
    cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd6}; cdb_value = {32'h601, 32'h600};
    step();
    idle();
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h22 || issue_vj !== 32'h600) begin
      errors++; $display("FAIL port_prio got v=%b op=%h vj=%h exp 1 22 600", issue_valid, issue_op, issue_vj);
    end
    step();
    issue_ready = 1'b0;
    $display("forward and port priority done");
  endtask

  task automatic test_back_pressure();
    issue_ready = 1'b0;
    dispatch(6'h31, 4'd0, 4'd0, 32'h310, 32'h0, 4'd1);
    step();
    dispatch(6'h32, 4'd0, 4'd0, 32'h320, 32'h0, 4'd2);
    step();
    dispatch(6'h33, 4'd0, 4'd0, 32'h330, 32'h0, 4'd3);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h31 || issue_vj !== 32'h310 || issue_dest !== 4'd1) begin
        errors++; $display("FAIL hold_%0d got v=%b op=%h vj=%h dest=%h exp 1 31 310 1", c, issue_valid, issue_op, issue_vj, issue_dest);
      end
    end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h32) begin
      errors++; $display("FAIL bp_next got v=%b op=%h exp 1 32", issue_valid, issue_op);
    end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h33) begin
      errors++; $display("FAIL bp_third got v=%b op=%h exp 1 33", issue_valid, issue_op);
    end
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", issue_valid); end
    issue_ready = 1'b0;
    $display("back pressure done");
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    dispatch(6'h01, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1);
    step();
    for (int k = 0; k < 5; k++) begin
      dispatch(6'(2 + k), 4'd4, 4'd0, 32'h0, 32'h0, 4'(2 + k));
      step();
    end
    idle();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h01) begin
      errors++; $display("FAIL flush_pre got v=%b op=%h exp 1 01", issue_valid, issue_op);
    end
    flush_in = 1'b1;
    dispatch(6'h3E, 4'd0, 4'd0, 32'h0, 32'h0, 4'd8);
    step();
    idle();
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0 || one_vacancy !== 1'b0) begin
      errors++; $display("FAIL flush_clear got v=%b full=%b onev=%b exp 0 0 0", issue_valid, full, one_vacancy);
    end
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4}; cdb_value = {32'h0, 32'h44};
    issue_ready = 1'b1;
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (issue_valid !== 1'b0) begin
        errors++; $display("FAIL flush_stale_%0d got v=%b op=%h exp v=0", c, issue_valid, issue_op);
      end
    end
    issue_ready = 1'b0;
    $display("flush done");
  endtask

  task automatic test_freeze();
    issue_ready = 1'b0;
    rdy_in = 1'b0;
    dispatch(6'h15, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1);
    step(); step();
    idle();
    rdy_in = 1'b1;
    step(); step();
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL freeze_disp got v=%b full=%b exp 0 0", issue_valid, full);
    end
    dispatch(6'h16, 4'd0, 4'd0, 32'h0, 32'h0, 4'd2);
    step();
    idle();
    step();
    rdy_in = 1'b0;
    issue_ready = 1'b1;
    step(); step();
    checks++; if (issue_valid !== 1'b1 || issue_op !== 6'h16) begin
      errors++; $display("FAIL freeze_hold got v=%b op=%h exp 1 16", issue_valid, issue_op);
    end
    rdy_in = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL freeze_release got %b exp 0", issue_valid); end
    issue_ready = 1'b0;
    $display("freeze done");
  endtask

  task automatic test_reset_override();
    issue_ready = 1'b0;
    dispatch(6'h17, 4'd0, 4'd0, 32'h0, 32'h0, 4'd3);
    step();
    idle();
    step();
    rst_in = 1'b1; rdy_in = 1'b0; flush_in = 1'b1;
    step();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    checks++; if (issue_valid !== 1'b0 || issue_op !== 6'h00 || issue_dest !== 4'h0) begin
      errors++; $display("FAIL reset_override got v=%b op=%h dest=%h exp 0 0 0", issue_valid, issue_op, issue_dest);
    end
    $display("reset override done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_age_order();
    test_fill();
    test_forward();
    test_back_pressure();
    test_flush();
    test_freeze();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
